// File: rtl/ts_packet_scheduler.sv
// Packet-level round-robin scheduler for the 4-input TS mux; switches streams only on packet edges.
// Optional build macro TS_STRICT_PRIO_EN gives stream 0 strict priority over a 1..3 round-robin.
module ts_packet_scheduler #(
    parameter int unsigned PKT_LEN = 188,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned TIMEOUT = 1023,
    parameter int unsigned TO_W    = 10
) (
    input  logic       clk2,
    input  logic       rst,
    input  logic       enable,
    input  logic [3:0] valid_in,
    input  logic [3:0] sync_in,
    input  logic       fifo_full,
    output logic [1:0] mux_ctrl,
    output logic       en_mux,
    output logic       busy,
    output logic       pkt_done,
    output logic       drop_pulse,
    output logic       sync_err,
    output logic       timeout_err
);

    typedef enum logic {StIdle, StPass} state_e;

    state_e            r_state, w_state_d;
    logic [1:0]        r_sel, w_sel_d;
    logic [1:0]        r_rr, w_rr_d;
    logic [CNT_W-1:0]  r_cnt, w_cnt_d;
    logic [TO_W-1:0]   r_stall, w_stall_d;
    logic              r_done, w_done_d;
    logic              r_drop, w_drop_d;
    logic              r_serr, w_serr_d;
    logic              r_to, w_to_d;

    logic [3:0]        w_cand;
    logic [1:0]        w_pick;
    logic [1:0]        w_rr_next;
    logic              w_found;
    logic              w_grant;
    logic              w_sel_valid;
    logic              w_sel_sync;

    assign w_cand      = valid_in & sync_in;
    assign w_sel_valid = valid_in[r_sel];
    assign w_sel_sync  = sync_in[r_sel];

`ifdef TS_STRICT_PRIO_EN
    logic [1:0] w_base;
    // Pointer never rests on 0 in this mode; a freshly reset pointer starts the 1..3 search at 1.
    assign w_base = (r_rr == 2'd0) ? 2'd1 : r_rr;

    always_comb begin
        w_pick  = 2'd0;
        w_found = 1'b0;
        if (w_cand[0]) begin
            w_pick  = 2'd0;
            w_found = 1'b1;
        end else begin
            for (int k = 0; k < 3; k++) begin
                int j;
                j = ((int'(w_base) - 1 + k) % 3) + 1;
                if (!w_found && w_cand[j]) begin
                    w_pick  = 2'(j);
                    w_found = 1'b1;
                end
            end
        end
        w_rr_next = (w_pick == 2'd3) ? 2'd1 : w_pick + 2'd1;
    end
`else
    always_comb begin
        w_pick  = 2'd0;
        w_found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            int j;
            j = (int'(r_rr) + k) % 4;
            if (!w_found && w_cand[j]) begin
                w_pick  = 2'(j);
                w_found = 1'b1;
            end
        end
        w_rr_next = w_pick + 2'd1;
    end
`endif

    assign w_grant = (r_state == StIdle) && enable && !fifo_full && w_found;

    always_comb begin
        w_state_d = r_state;
        w_sel_d   = r_sel;
        w_rr_d    = r_rr;
        w_cnt_d   = r_cnt;
        w_stall_d = r_stall;
        w_done_d  = 1'b0;
        w_drop_d  = 1'b0;
        w_serr_d  = 1'b0;
        w_to_d    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_grant) begin
                    w_sel_d   = w_pick;
                    w_rr_d    = w_rr_next;
                    w_cnt_d   = CNT_W'(1);
                    w_stall_d = '0;
                    w_state_d = StPass;
                end
            end
            StPass: begin
                if (w_sel_valid) begin
                    w_stall_d = '0;
                    // Byte is counted even when the FIFO drops it, keeping packet alignment.
                    w_drop_d  = fifo_full;
                    if (w_sel_sync && (r_cnt != '0)) begin
                        w_cnt_d  = CNT_W'(1);
                        w_serr_d = 1'b1;
                    end else if (r_cnt == CNT_W'(PKT_LEN - 1)) begin
                        w_cnt_d   = '0;
                        w_done_d  = 1'b1;
                        w_state_d = StIdle;
                    end else begin
                        w_cnt_d = r_cnt + CNT_W'(1);
                    end
                end else if (r_stall == TO_W'(TIMEOUT - 1)) begin
                    w_stall_d = '0;
                    w_cnt_d   = '0;
                    w_to_d    = 1'b1;
                    w_state_d = StIdle;
                end else begin
                    w_stall_d = r_stall + TO_W'(1);
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_comb begin
        mux_ctrl = r_sel;
        en_mux   = 1'b0;
        busy     = 1'b0;
        if (rst) begin
            mux_ctrl = 2'd0;
        end else if (w_grant) begin
            mux_ctrl = w_pick;
            en_mux   = 1'b1;
        end else if (r_state == StPass) begin
            busy   = 1'b1;
            en_mux = w_sel_valid && !fifo_full;
        end
    end

    always_ff @(posedge clk2) begin
        if (rst) begin
            r_state <= StIdle;
            r_sel   <= '0;
            r_rr    <= '0;
            r_cnt   <= '0;
            r_stall <= '0;
            r_done  <= 1'b0;
            r_drop  <= 1'b0;
            r_serr  <= 1'b0;
            r_to    <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_sel   <= w_sel_d;
            r_rr    <= w_rr_d;
            r_cnt   <= w_cnt_d;
            r_stall <= w_stall_d;
            r_done  <= w_done_d;
            r_drop  <= w_drop_d;
            r_serr  <= w_serr_d;
            r_to    <= w_to_d;
        end
    end

    assign pkt_done    = r_done;
    assign drop_pulse  = r_drop;
    assign sync_err    = r_serr;
    assign timeout_err = r_to;

endmodule

// File: tb/tb_ts_packet_scheduler.sv
// Directed bench for ts_packet_scheduler: grant order, packet length, backpressure, resync,
// stall timeout and reset abandonment, with expected values worked out by hand.
module tb_ts_packet_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [3:0] valid_in;
    logic [3:0] sync_in;
    logic       fifo_full;
    logic [1:0] mux_ctrl;
    logic       en_mux;
    logic       busy;
    logic       pkt_done;
    logic       drop_pulse;
    logic       sync_err;
    logic       timeout_err;

    int total = 0;
    int bad   = 0;

    logic       s_en, s_busy, s_done, s_drop, s_serr, s_to;
    logic [1:0] s_mux;
    logic [1:0] exp_mux;
    int         n_en, n_done, n_drop, n_serr, n_to, n_muxbad;
    int         exp_v;

    ts_packet_scheduler dut (
        .clk2        (clk),
        .rst         (rst),
        .enable      (enable),
        .valid_in    (valid_in),
        .sync_in     (sync_in),
        .fifo_full   (fifo_full),
        .mux_ctrl    (mux_ctrl),
        .en_mux      (en_mux),
        .busy        (busy),
        .pkt_done    (pkt_done),
        .drop_pulse  (drop_pulse),
        .sync_err    (sync_err),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic clr();
        n_en = 0; n_done = 0; n_drop = 0; n_serr = 0; n_to = 0; n_muxbad = 0;
    endtask

    // One clock cycle: drive at negedge, sample combinational outputs, then registered pulses.
    task automatic cyc(input logic r, input logic en, input logic [3:0] v, input logic [3:0] s,
                       input logic ff);
        rst = r; enable = en; valid_in = v; sync_in = s; fifo_full = ff;
        #1;
        s_en = en_mux; s_mux = mux_ctrl; s_busy = busy;
        if (en_mux === 1'b1) n_en++;
        if (mux_ctrl !== exp_mux) n_muxbad++;
        @(posedge clk);
        #1;
        s_done = pkt_done; s_drop = drop_pulse; s_serr = sync_err; s_to = timeout_err;
        if (pkt_done === 1'b1) n_done++;
        if (drop_pulse === 1'b1) n_drop++;
        if (sync_err === 1'b1) n_serr++;
        if (timeout_err === 1'b1) n_to++;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1; valid_in = '0; sync_in = '0; fifo_full = 1'b0;
        exp_mux = 2'd0;
        clr();
        @(negedge clk);

        // Reset with candidates present: nothing granted
        cyc(1, 1, 4'hF, 4'hF, 0);
        chk("rst_en", 32'(s_en), 0);
        chk("rst_busy", 32'(s_busy), 0);
        chk("rst_mux", 32'(s_mux), 0);
        cyc(1, 1, 4'hF, 4'hF, 0);
        chk("rst_pulses", 32'({s_done, s_drop, s_serr, s_to}), 0);

        // Single packet on stream 2
        clr(); exp_mux = 2'd2;
        cyc(0, 1, 4'b0100, 4'b0100, 0);
        chk("t1_grant_mux", 32'(s_mux), 2);
        chk("t1_grant_en", 32'(s_en), 1);
        repeat (186) cyc(0, 1, 4'b0100, 4'b0000, 0);
        chk("t1_no_early_done", 32'(n_done), 0);
        cyc(0, 1, 4'b0100, 4'b0000, 0);
        chk("t1_done_last", 32'(s_done), 1);
        chk("t1_en_count", 32'(n_en), 188);
        cyc(0, 1, 4'b0000, 4'b0000, 0);
        chk("t1_busy_after", 32'(s_busy), 0);
        chk("t1_done_once", 32'(n_done), 1);
        chk("t1_mux_stable", 32'(n_muxbad), 0);
        cyc(0, 0, 4'b0100, 4'b0100, 0);
        chk("enable_low_blocks", 32'(s_en), 0);

        // All four streams ready: rotation from rr_ptr=0
        cyc(1, 1, 4'h0, 4'h0, 0);
        for (int p = 0; p < 5; p++) begin
            clr();
`ifdef TS_STRICT_PRIO_EN
            exp_mux = 2'd0;
`else
            exp_mux = 2'(p % 4);
`endif
            cyc(0, 1, 4'hF, 4'hF, 0);
            chk($sformatf("t2_grant_mux_%0d", p), 32'(s_mux), 32'(exp_mux));
            repeat (187) cyc(0, 1, 4'hF, 4'h0, 0);
            chk($sformatf("t2_en_count_%0d", p), 32'(n_en), 188);
            chk($sformatf("t2_done_%0d", p), 32'(n_done), 1);
            chk($sformatf("t2_mux_stable_%0d", p), 32'(n_muxbad), 0);
        end

        // Backpressure on stream 1 for 5 cycles at cnt=50
        clr(); exp_mux = 2'd1;
        cyc(0, 1, 4'b0010, 4'b0010, 0);
        chk("t3_grant_mux", 32'(s_mux), 1);
        repeat (49) cyc(0, 1, 4'b0010, 4'b0000, 0);
        repeat (5) cyc(0, 1, 4'b0010, 4'b0000, 1);
        chk("t3_en_blocked", 32'(n_en), 50);
        chk("t3_drops", 32'(n_drop), 5);
        repeat (132) cyc(0, 1, 4'b0010, 4'b0000, 0);
        chk("t3_no_early_done", 32'(n_done), 0);
        cyc(0, 1, 4'b0010, 4'b0000, 0);
        chk("t3_done_last", 32'(s_done), 1);
        chk("t3_en_count", 32'(n_en), 183);
        cyc(0, 1, 4'b0010, 4'b0010, 1);
        chk("t3_full_blocks_grant", 32'(s_en), 0);
        cyc(0, 1, 4'b0000, 4'b0000, 0);
        chk("t3_idle_after_block", 32'(s_busy), 0);

        // Resync on stream 3 at cnt=100
        clr(); exp_mux = 2'd3;
        cyc(0, 1, 4'b1000, 4'b1000, 0);
        chk("t4_grant_mux", 32'(s_mux), 3);
        repeat (99) cyc(0, 1, 4'b1000, 4'b0000, 0);
        cyc(0, 1, 4'b1000, 4'b1000, 0);
        chk("t4_sync_err", 32'(s_serr), 1);
        chk("t4_resync_written", 32'(s_en), 1);
        repeat (186) cyc(0, 1, 4'b1000, 4'b0000, 0);
        chk("t4_no_early_done", 32'(n_done), 0);
        cyc(0, 1, 4'b1000, 4'b0000, 0);
        chk("t4_done_last", 32'(s_done), 1);
        chk("t4_serr_once", 32'(n_serr), 1);
        chk("t4_en_count", 32'(n_en), 288);

        // Stall timeout on stream 0, then stream 1 granted, then reset mid-packet
        clr(); exp_mux = 2'd0;
        cyc(0, 1, 4'b0001, 4'b0001, 0);
        chk("t5_grant_mux", 32'(s_mux), 0);
        repeat (9) cyc(0, 1, 4'b0001, 4'b0000, 0);
        repeat (1022) cyc(0, 1, 4'b0000, 4'b0000, 0);
        chk("t5_no_early_to", 32'(n_to), 0);
        cyc(0, 1, 4'b0000, 4'b0000, 0);
        chk("t5_timeout", 32'(s_to), 1);
        chk("t5_busy_until_abort", 32'(s_busy), 1);
        chk("t5_mux_stable", 32'(n_muxbad), 0);
        exp_mux = 2'd1;
        cyc(0, 1, 4'b0010, 4'b0010, 0);
        chk("t5_next_grant_mux", 32'(s_mux), 1);
        chk("t5_next_grant_en", 32'(s_en), 1);
        repeat (89) cyc(0, 1, 4'b0010, 4'b0000, 0);
        cyc(1, 1, 4'b0010, 4'b0000, 0);
        chk("t5_rst_en", 32'(s_en), 0);
        chk("t5_rst_busy", 32'(s_busy), 0);
        chk("t5_rst_mux", 32'(s_mux), 0);
        cyc(0, 1, 4'b0010, 4'b0000, 0);
        chk("t5_post_rst_en", 32'(s_en), 0);
        chk("t5_post_rst_busy", 32'(s_busy), 0);
        chk("t5_post_rst_mux", 32'(s_mux), 0);

        // Streams 0 and 2 pending after every packet
        for (int p = 0; p < 3; p++) begin
            clr();
`ifdef TS_STRICT_PRIO_EN
            exp_v = 0;
`else
            exp_v = (p % 2 == 1) ? 2 : 0;
`endif
            exp_mux = 2'(exp_v);
            cyc(0, 1, 4'b0101, 4'b0101, 0);
            chk($sformatf("t6_grant_mux_%0d", p), 32'(s_mux), 32'(exp_v));
            repeat (187) cyc(0, 1, 4'b0101, 4'b0000, 0);
            chk($sformatf("t6_en_count_%0d", p), 32'(n_en), 188);
            chk($sformatf("t6_done_%0d", p), 32'(n_done), 1);
            chk($sformatf("t6_mux_stable_%0d", p), 32'(n_muxbad), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
